// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI encodings, line address fields and
// the miss-request FSM state type.
package cc_pkg;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam int         CC_LINE_BEATS  = 8;

  // Line address fields: offset [5:0], word [5:3], index [14:6], tag [31:15]
  localparam int OFF_MSB  = 5;
  localparam int OFF_LSB  = 0;
  localparam int WORD_MSB = 5;
  localparam int WORD_LSB = 3;
  localparam int IDX_MSB  = 14;
  localparam int IDX_LSB  = 6;
  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 15;

  typedef enum logic {S_IDLE, S_AR} cc_state_e;

  // Critical-word-first: the burst starts at the 8-byte beat holding the miss.
  function automatic logic [31:0] beat_align(input logic [31:0] a);
    return a & ~32'((1 << WORD_LSB) - 1);
  endfunction
endpackage

// File: rtl/cc_miss_req_unit_if.sv
// Miss request, AXI AR, snooped R and miss-address FIFO push signals.
interface cc_miss_req_unit_if;
  logic        miss_valid_i;
  logic [31:0] miss_addr_i;
  logic        miss_ready_o;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;

  modport master (
    input  miss_valid_i, miss_addr_i, arready_i,
           mem_rvalid_i, mem_rready_i, mem_rlast_i, miss_addr_fifo_full_i,
    output miss_ready_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
           miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o
  );

  modport slave (
    output miss_valid_i, miss_addr_i, arready_i,
           mem_rvalid_i, mem_rready_i, mem_rlast_i, miss_addr_fifo_full_i,
    input  miss_ready_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
           miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o
  );
endinterface

// File: rtl/cc_miss_req_unit.sv
// Turns a tag miss into one WRAP line-fill AR burst plus a miss-address FIFO push,
// throttled by FIFO space and the number of bursts still awaiting rlast.
module cc_miss_req_unit
  import cc_pkg::*;
#(
  parameter int         MAX_OUTST = 2,
  parameter logic [3:0] ARID_VAL  = 4'd0
) (
  input logic               clk,
  input logic               rst_n,
  cc_miss_req_unit_if.master bus
);
  cc_state_e  state;
  logic [2:0] outst;
  logic       accept, ar_hs, r_done;

  assign bus.arid_o    = ARID_VAL;
  assign bus.arlen_o   = 8'(CC_LINE_BEATS - 1);
  assign bus.arsize_o  = AXI_SIZE_8B;
  assign bus.arburst_o = AXI_BURST_WRAP;

  assign bus.miss_ready_o = (state == S_IDLE) && !bus.miss_addr_fifo_full_i &&
                            (outst < 3'(MAX_OUTST));
  assign accept = bus.miss_valid_i && bus.miss_ready_o;
  assign ar_hs  = bus.arvalid_o && bus.arready_i;
  assign r_done = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;

  // The FIFO push coincides with arvalid rising, so the fill stage always has
  // the address before the first R beat of the burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                      <= S_IDLE;
      bus.arvalid_o              <= 1'b0;
      bus.araddr_o               <= '0;
      bus.miss_addr_fifo_wren_o  <= 1'b0;
      bus.miss_addr_fifo_wdata_o <= '0;
    end else begin
      bus.miss_addr_fifo_wren_o <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          bus.araddr_o               <= beat_align(bus.miss_addr_i);
          bus.miss_addr_fifo_wdata_o <= bus.miss_addr_i;
          bus.miss_addr_fifo_wren_o  <= 1'b1;
          bus.arvalid_o              <= 1'b1;
          state                      <= S_AR;
        end
        S_AR: if (bus.arready_i) begin
          bus.arvalid_o <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bursts issued but not yet terminated by rlast; saturates at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) outst <= '0;
    else begin
      case ({ar_hs, r_done})
        2'b10:   outst <= outst + 3'd1;
        2'b01:   if (outst != 3'd0) outst <= outst - 3'd1;
        default: outst <= outst;
      endcase
    end
  end

  a_araddr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    bus.arvalid_o && !bus.arready_i |=> $stable(bus.araddr_o));
  a_push_space: assert property (@(posedge clk) disable iff (!rst_n)
    bus.miss_addr_fifo_wren_o |-> $past(!bus.miss_addr_fifo_full_i));
  a_outst_max: assert property (@(posedge clk) disable iff (!rst_n)
    outst <= 3'(MAX_OUTST));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    r_done |-> outst != 3'd0);
endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Directed bench for cc_miss_req_unit with an AR/FIFO-push scoreboard.
module tb_cc_miss_req_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   n_push = 0;
  int   n_ar   = 0;
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_fifo_q[$];

  always #5 clk = ~clk;

  cc_miss_req_unit_if bus();

  cc_miss_req_unit #(.MAX_OUTST(2), .ARID_VAL(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic r_beat(input logic last);
    bus.mem_rvalid_i = 1'b1; bus.mem_rready_i = 1'b1; bus.mem_rlast_i = last;
    tick();
    bus.mem_rvalid_i = 1'b0; bus.mem_rready_i = 1'b0; bus.mem_rlast_i = 1'b0;
  endtask

  // Scoreboard: expectations pushed on accept, popped on push / AR handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ar_q.delete();
      exp_fifo_q.delete();
    end else begin
      if (bus.miss_addr_fifo_wren_o) begin
        n_push++;
        if (exp_fifo_q.size() == 0) chk("fifo_unexpected_push", 32'd1, 32'd0);
        else chk("fifo_wdata", bus.miss_addr_fifo_wdata_o, exp_fifo_q.pop_front());
      end
      if (bus.arvalid_o && bus.arready_i) begin
        n_ar++;
        if (exp_ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
        else begin
          chk("araddr", bus.araddr_o, exp_ar_q.pop_front());
          chk("arlen", 32'(bus.arlen_o), 32'd7);
          chk("arsize", 32'(bus.arsize_o), 32'd3);
          chk("arburst", 32'(bus.arburst_o), 32'd2);
          chk("arid", 32'(bus.arid_o), 32'd0);
        end
      end
      if (bus.miss_valid_i && bus.miss_ready_o) begin
        exp_ar_q.push_back({bus.miss_addr_i[31:3], 3'b000});
        exp_fifo_q.push_back(bus.miss_addr_i);
      end
    end
  end

  initial begin
    int p0;
    rst_n = 1'b0;
    bus.miss_valid_i = 1'b0; bus.miss_addr_i = '0; bus.arready_i = 1'b0;
    bus.mem_rvalid_i = 1'b0; bus.mem_rready_i = 1'b0; bus.mem_rlast_i = 1'b0;
    bus.miss_addr_fifo_full_i = 1'b0;
    repeat (3) tick();
    chk("rst_arvalid", 32'(bus.arvalid_o), 32'd0);
    chk("rst_araddr", bus.araddr_o, 32'd0);
    chk("rst_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
    chk("rst_wdata", bus.miss_addr_fifo_wdata_o, 32'd0);
    chk("rst_outst", 32'(dut.outst), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(bus.miss_ready_o), 32'd1);

    // Single miss
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0001_2348;
    tick();
    bus.miss_valid_i = 1'b0; bus.arready_i = 1'b1;
    chk("s_arvalid", 32'(bus.arvalid_o), 32'd1);
    chk("s_araddr", bus.araddr_o, 32'h0001_2348);
    chk("s_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd1);
    chk("s_ready_ar", 32'(bus.miss_ready_o), 32'd0);
    tick();
    bus.arready_i = 1'b0;
    chk("s_arvalid_drop", 32'(bus.arvalid_o), 32'd0);
    chk("s_wren_1cyc", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
    chk("s_outst1", 32'(dut.outst), 32'd1);
    for (int i = 0; i < 7; i++) r_beat(1'b0);
    chk("s_outst_pre_last", 32'(dut.outst), 32'd1);
    r_beat(1'b1);
    chk("s_outst0", 32'(dut.outst), 32'd0);

    // Backpressure
    p0 = n_push;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_0044;
    tick();
    bus.miss_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("bp_arvalid", 32'(bus.arvalid_o), 32'd1);
      chk("bp_araddr", bus.araddr_o, 32'h0000_0040);
      chk("bp_ready", 32'(bus.miss_ready_o), 32'd0);
      if (i < 5) tick();
    end
    bus.arready_i = 1'b1;
    tick();
    bus.arready_i = 1'b0;
    chk("bp_arvalid_drop", 32'(bus.arvalid_o), 32'd0);
    chk("bp_one_push", 32'(n_push - p0), 32'd1);
    chk("bp_outst", 32'(dut.outst), 32'd1);
    r_beat(1'b1);
    chk("bp_outst0", 32'(dut.outst), 32'd0);

    // Outstanding limit: third miss waits for an rlast
    bus.arready_i = 1'b1;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_0100;
    tick();
    bus.miss_addr_i = 32'h0000_0208;
    tick();
    chk("ol_ready_1", 32'(bus.miss_ready_o), 32'd1);
    tick();
    bus.miss_addr_i = 32'h0000_0310;
    tick();
    chk("ol_outst2", 32'(dut.outst), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("ol_ready_blocked", 32'(bus.miss_ready_o), 32'd0);
      chk("ol_no_ar", 32'(bus.arvalid_o), 32'd0);
      tick();
    end
    r_beat(1'b1);
    chk("ol_ready_after_rlast", 32'(bus.miss_ready_o), 32'd1);
    tick();
    bus.miss_valid_i = 1'b0;
    chk("ol_third_arvalid", 32'(bus.arvalid_o), 32'd1);
    chk("ol_third_araddr", bus.araddr_o, 32'h0000_0310);
    tick();
    chk("ol_outst_back2", 32'(dut.outst), 32'd2);
    r_beat(1'b1);
    r_beat(1'b1);
    chk("ol_outst0", 32'(dut.outst), 32'd0);
    chk("ol_ar_count", 32'(n_ar), 32'd5);

    // FIFO full
    bus.arready_i = 1'b0;
    bus.miss_addr_fifo_full_i = 1'b1;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_0500;
    #1;
    p0 = n_push;
    for (int i = 0; i < 3; i++) begin
      chk("ff_ready", 32'(bus.miss_ready_o), 32'd0);
      tick();
      chk("ff_no_ar", 32'(bus.arvalid_o), 32'd0);
      chk("ff_no_push", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
    end
    bus.miss_addr_fifo_full_i = 1'b0;
    #1;
    chk("ff_release_ready", 32'(bus.miss_ready_o), 32'd1);
    tick();
    bus.miss_valid_i = 1'b0;
    bus.miss_addr_fifo_full_i = 1'b1;
    chk("ff_accept_arvalid", 32'(bus.arvalid_o), 32'd1);
    chk("ff_accept_push", 32'(bus.miss_addr_fifo_wren_o), 32'd1);
    bus.arready_i = 1'b1;
    tick();
    bus.arready_i = 1'b0;
    bus.miss_addr_fifo_full_i = 1'b0;
    chk("ff_pushes", 32'(n_push - p0), 32'd1);
    chk("ff_outst", 32'(dut.outst), 32'd1);

    // AR handshake and rlast together with outst=1
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_0608;
    tick();
    bus.miss_valid_i = 1'b0;
    bus.arready_i = 1'b1;
    r_beat(1'b1);
    bus.arready_i = 1'b0;
    chk("sim_outst", 32'(dut.outst), 32'd1);

    // Reset while in AR
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_0700;
    tick();
    bus.miss_valid_i = 1'b0;
    chk("rm_in_ar", 32'(bus.arvalid_o), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rm_arvalid", 32'(bus.arvalid_o), 32'd0);
    chk("rm_outst", 32'(dut.outst), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rm_ready", 32'(bus.miss_ready_o), 32'd1);
    tick();
    chk("rm_idle_arvalid", 32'(bus.arvalid_o), 32'd0);
    chk("sb_ar_empty", 32'(exp_ar_q.size()), 32'd0);
    chk("sb_fifo_empty", 32'(exp_fifo_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
